// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmitter arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    LAUNCH    = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int N_REQ_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 65535;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  int idx;

  // Walk from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx[PW-1:0]]) gnt = N'(1) << idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter sharing one UART transmitter among N_REQ producers.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_enable,
  input  logic               tx_busy,
  output logic               err_timeout
);

  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [PW-1:0]    owner_q;
  logic [PW-1:0]    ptr_q;
  logic [7:0]       tx_data_q;
  logic             tx_enable_q;
  logic             err_q;
  logic             last_q;
  logic [WW-1:0]    wd_q;

  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic [PW-1:0]    pick_idx_d;
  logic [PW-1:0]    next_ptr_d;
  logic [7:0]       own_data_d;
  logic             own_valid_d;
  logic             own_last_d;
  logic [WW-1:0]    wd_inc_d;
  logic             wd_fire_d;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  always_comb begin
    pick_idx_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) pick_idx_d = PW'(i);
    end
  end

  assign own_data_d  = req_data[{owner_q, 3'b000} +: 8];
  assign own_valid_d = req_valid[owner_q];
  assign own_last_d  = req_last[owner_q];
  assign next_ptr_d  = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
  assign wd_inc_d    = wd_q + WW'(1);
  assign wd_fire_d   = (wd_inc_d >= WW'(TIMEOUT));

  // Only the locked owner ever sees ready, and only while a byte is wanted.
  assign req_ready   = (state_q == GRANT) ? (grant_q & req_valid) : '0;
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_enable   = tx_enable_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      wd_q        <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q <= pick_idx_d;
            grant_q <= pick_gnt;
            wd_q    <= '0;
            state_q <= GRANT;
          end
        end
        // Acceptance and busy-rise are tested before the watchdog so they win a tie.
        GRANT: begin
          if (own_valid_d) begin
            tx_data_q   <= own_data_d;
            last_q      <= own_last_d;
            tx_enable_q <= 1'b1;
            wd_q        <= '0;
            state_q     <= LAUNCH;
          end else if (wd_fire_d) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            ptr_q   <= next_ptr_d;
            wd_q    <= '0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_inc_d;
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            tx_enable_q <= 1'b0;
            wd_q        <= '0;
            state_q     <= WAIT_DONE;
          end else if (wd_fire_d) begin
            err_q       <= 1'b1;
            tx_enable_q <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= next_ptr_d;
            wd_q        <= '0;
            state_q     <= IDLE;
          end else begin
            wd_q <= wd_inc_d;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            wd_q <= '0;
            if (last_q) begin
              ptr_q   <= next_ptr_d;
              grant_q <= '0;
              state_q <= IDLE;
            end else begin
              state_q <= GRANT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin model plus directed watchdog/reset steps.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int TO_MAIN = 64;
  localparam int TO_WD   = 8;
  localparam int FRAME   = 10;

  bit clk;
  always #5 clk = ~clk;
  logic rst_n;

  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_enable, err_timeout, tx_busy;

  logic [N-1:0]   w_valid, w_last, w_ready, w_grant;
  logic [8*N-1:0] w_data;
  logic [7:0]     w_txd;
  logic           w_en, w_err, w_busy;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_enable(tx_enable), .tx_busy(tx_busy), .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO_WD)) dut_wd (
    .clk(clk), .rst_n(rst_n), .req_valid(w_valid), .req_data(w_data),
    .req_last(w_last), .req_ready(w_ready), .grant(w_grant), .tx_data(w_txd),
    .tx_enable(w_en), .tx_busy(w_busy), .err_timeout(w_err)
  );

  // Transmitter models: busy rises one clk after enable is sampled, lasts FRAME clks,
  // and is never cut short by the arbiter's reset.
  int bcnt, wbcnt;
  bit w_model_on;
  assign tx_busy = (bcnt != 0);
  assign w_busy  = (wbcnt != 0);
  always @(posedge clk) begin
    if (bcnt != 0) bcnt <= bcnt - 1;
    else if (tx_enable === 1'b1) bcnt <= FRAME;
  end
  always @(posedge clk) begin
    if (wbcnt != 0) wbcnt <= wbcnt - 1;
    else if (w_model_on && w_en === 1'b1) wbcnt <= FRAME;
  end

  int n_cmp, n_bad;
  logic [8:0] drv_q [N][$];
  logic [8:0] mdl_q [N][$];
  int gap [N];
  bit hold [N];
  bit rand_gaps;
  int exp_own[$], log_own[$];
  logic [7:0] exp_byte[$], log_byte[$];
  int m_ptr, rdy_viol;
  logic en_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) oh_idx = (oh_idx == -1) ? i : -2;
  endfunction

  function automatic bit pending();
    pending = 0;
    for (int r = 0; r < N; r++) if (drv_q[r].size() != 0) pending = 1;
  endfunction

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (drv_q[r].size() != 0) begin
        req_valid[r]       = !hold[r] && gap[r] == 0;
        req_data[8*r +: 8] = drv_q[r][0][7:0];
        req_last[r]        = drv_q[r][0][8];
      end else begin
        req_valid[r]       = 1'b0;
        req_data[8*r +: 8] = 8'h00;
        req_last[r]        = 1'b0;
      end
    end
  endtask

  // One clock: capture handshakes mid-cycle, sample 1 time unit after the edge, then re-drive.
  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk); #1;
    if ((req_ready & ~grant) != '0 || (req_ready & ~req_valid) != '0) rdy_viol++;
    if (tx_enable === 1'b1 && en_prev !== 1'b1) begin
      log_own.push_back(oh_idx(grant));
      log_byte.push_back(tx_data);
    end
    en_prev = tx_enable;
    for (int r = 0; r < N; r++) begin
      if (hs[r] && drv_q[r].size() != 0) begin
        if (rand_gaps && !drv_q[r][0][8]) gap[r] = $urandom_range(0, 3);
        void'(drv_q[r].pop_front());
      end else if (gap[r] > 0) begin
        gap[r]--;
      end
    end
    drive();
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input logic last);
    drv_q[r].push_back({last, b});
    mdl_q[r].push_back({last, b});
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int i = 0; i < len; i++) add_byte(r, 8'($urandom_range(0, 255)), i == len - 1);
  endtask

  // Reference: whole packets served in round-robin order from the pointer left by the last packet.
  task automatic model_drain();
    int owner;
    logic [8:0] b;
    forever begin
      owner = -1;
      for (int k = N - 1; k >= 0; k--)
        if (mdl_q[(m_ptr + k) % N].size() != 0) owner = (m_ptr + k) % N;
      if (owner < 0) break;
      do begin
        b = mdl_q[owner].pop_front();
        exp_own.push_back(owner);
        exp_byte.push_back(b[7:0]);
      end while (!b[8]);
      m_ptr = (owner + 1) % N;
    end
  endtask

  task automatic wait_and_check(input string tag);
    int t;
    t = 0;
    while (log_own.size() < exp_own.size() && t < 20000) begin tick(); t++; end
    t = 0;
    while ((grant != '0 || tx_busy || pending()) && t < 2000) begin tick(); t++; end
    chk({tag, " idle grant"}, grant, '0);
    chk({tag, " byte count"}, log_own.size(), exp_own.size());
    for (int i = 0; i < exp_own.size() && i < log_own.size(); i++) begin
      $display("%s #%0d: req%0d byte 0x%02h (model req%0d 0x%02h)",
               tag, i, log_own[i], log_byte[i], exp_own[i], exp_byte[i]);
      chk($sformatf("%s owner[%0d]", tag, i), log_own[i], exp_own[i]);
      chk($sformatf("%s byte[%0d]", tag, i), log_byte[i], exp_byte[i]);
    end
    exp_own.delete(); exp_byte.delete(); log_own.delete(); log_byte.delete();
  endtask

  task automatic clear_tb();
    for (int r = 0; r < N; r++) begin
      drv_q[r].delete(); mdl_q[r].delete(); gap[r] = 0; hold[r] = 0;
    end
    exp_own.delete(); exp_byte.delete(); log_own.delete(); log_byte.delete();
    m_ptr = 0; en_prev = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    clear_tb();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int t, en_cnt, err_cnt, stall_bad, lock_bad;
    rst_n = 1'b0;
    w_valid = '0; w_last = '0; w_data = '0; w_model_on = 0;
    rand_gaps = 0; rdy_viol = 0;
    clear_tb();
    repeat (3) @(posedge clk);
    #1;
    chk("reset grant", grant, '0);
    chk("reset req_ready", req_ready, '0);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset tx_enable", tx_enable, 1'b0);
    chk("reset err_timeout", err_timeout, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Launch watchdog: transmitter never answers.
    w_valid = 4'b0010; w_data = 32'h0000_5A00; w_last = 4'b0010;
    t = 0; while (w_ready !== 4'b0010 && t < 20) begin tick(); t++; end
    chk("wd_launch grant", w_grant, 4'b0010);
    tick(); w_valid = '0;
    chk("wd_launch tx_data", w_txd, 8'h5A);
    en_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (w_en) en_cnt++;
      if (w_err) begin
        err_cnt++;
        chk("wd_launch grant at err", w_grant, '0);
      end
      tick();
    end
    chk("wd_launch enable clks", en_cnt, TO_WD);
    chk("wd_launch err pulses", err_cnt, 1);
    chk("wd_launch grant after", w_grant, '0);

    // Stall watchdog: owner 2 stops before last; requester 3 waits behind the lock.
    w_model_on = 1;
    w_valid = 4'b1100; w_data = 32'h4433_0000; w_last = 4'b1000;
    stall_bad = 0;
    t = 0; while (w_ready[2] !== 1'b1 && t < 20) begin tick(); t++; end
    chk("wd_stall grant", w_grant, 4'b0100);
    tick(); w_valid[2] = 1'b0;
    t = 0; while (!w_busy && t < 20) begin tick(); t++; if (w_ready[3]) stall_bad++; end
    t = 0; while (w_busy && t < 30) begin tick(); t++; if (w_ready[3]) stall_bad++; end
    t = 0; while (w_err !== 1'b1 && t < 30) begin tick(); t++; if (w_ready[3]) stall_bad++; end
    chk("wd_stall clks from busy fall to err", t, TO_WD + 1);
    tick();
    chk("wd_stall next grant", w_grant, 4'b1000);
    chk("wd_stall non-owner ready", stall_bad, 0);
    w_valid = '0; w_model_on = 0;

    // Single packet from requester 1, then all four to expose the advanced pointer.
    do_reset();
    add_byte(1, 8'h41, 1'b0); add_byte(1, 8'h42, 1'b1);
    model_drain(); drive();
    wait_and_check("single");
    for (int r = 0; r < N; r++) add_pkt(r, 1);
    model_drain(); drive();
    wait_and_check("after_single");

    // Fairness from ptr 0 with requester 0 holding two packets.
    do_reset();
    add_pkt(0, 1); add_pkt(0, 1);
    for (int r = 1; r < N; r++) add_pkt(r, 1);
    model_drain(); drive();
    wait_and_check("fair");

    // Requester 3 alone first, others arrive while it owns the transmitter.
    do_reset();
    add_pkt(3, 1);
    model_drain(); drive();
    t = 0; while (grant !== 4'b1000 && t < 20) begin tick(); t++; end
    chk("late grant3 first", grant, 4'b1000);
    for (int r = 0; r < N; r++) add_pkt(r, 1);
    model_drain(); drive();
    wait_and_check("late");

    // Lock: owner 0 pauses mid-packet while requester 2 is valid.
    do_reset();
    add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b1);
    drive();
    t = 0; while (drv_q[0].size() != 1 && t < 20) begin tick(); t++; end
    hold[0] = 1; add_pkt(2, 1);
    model_drain(); drive();
    lock_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant !== 4'b0001 || req_ready[2] !== 1'b0) lock_bad++;
    end
    chk("lock held cycles violated", lock_bad, 0);
    hold[0] = 0; drive();
    wait_and_check("lock");

    // Randomised packets with mid-packet valid gaps.
    rand_gaps = 1;
    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < N; r++)
        for (int p = $urandom_range(0, 2); p > 0; p--) add_pkt(r, $urandom_range(1, 3));
      model_drain(); drive();
      wait_and_check($sformatf("rand%0d", round));
    end
    rand_gaps = 0;

    // Asynchronous reset while waiting for the frame to finish.
    add_byte(1, 8'hC3, 1'b1);
    drive();
    t = 0; while (!(grant != '0 && tx_busy && !tx_enable) && t < 40) begin tick(); t++; end
    chk("rst_wait reached wait_done", grant, 4'b0010);
    #3; rst_n = 1'b0; #1;
    chk("rst_wait grant", grant, '0);
    chk("rst_wait req_ready", req_ready, '0);
    chk("rst_wait tx_data", tx_data, 8'h00);
    chk("rst_wait tx_enable", tx_enable, 1'b0);
    chk("rst_wait err_timeout", err_timeout, 1'b0);
    clear_tb();
    @(negedge clk); rst_n = 1'b1;
    t = 0; while (tx_busy && t < 30) begin tick(); t++; end
    add_pkt(2, 1); add_pkt(0, 2);
    model_drain(); drive();
    wait_and_check("post_reset");

    chk("ready outside owner/valid", rdy_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
